// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the ALU issue stage.
// It holds the RV32I opcode values, the instruction field positions, the
// ALU request payload struct and the skid-buffer state encoding.
package alu_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;

    // RV32I instruction field bit positions
    localparam int unsigned OPCODE_LSB = 0;
    localparam int unsigned OPCODE_MSB = 6;
    localparam int unsigned RD_LSB     = 7;
    localparam int unsigned RD_MSB     = 11;
    localparam int unsigned FUNCT3_LSB = 12;
    localparam int unsigned FUNCT3_MSB = 14;
    localparam int unsigned RS1_LSB    = 15;
    localparam int unsigned RS1_MSB    = 19;
    localparam int unsigned RS2_LSB    = 20;
    localparam int unsigned RS2_MSB    = 24;
    localparam int unsigned FUNCT7_LSB = 25;
    localparam int unsigned FUNCT7_MSB = 31;
    localparam int unsigned IMM_LSB    = 20;
    localparam int unsigned IMM_MSB    = 31;
    localparam int unsigned IMM_W      = IMM_MSB - IMM_LSB + 1;

    // One decoded ALU request as carried through the skid buffer
    typedef struct packed {
        logic [XLEN-1:0]   operand1;
        logic [XLEN-1:0]   operand2;
        logic [6:0]        opcode;
        logic [2:0]        funct3;
        logic [6:0]        funct7;
        logic [REG_AW-1:0] rd;
        logic              illegal;
    } alu_req_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } E_BUF_STATE;

    function automatic logic is_alu_opcode(input logic [6:0] opc);
        return (opc == OPCODE_OP) || (opc == OPCODE_OP_IMM);
    endfunction

endpackage

// File: rtl/alu_issue_stage_if.sv
// alu_issue_stage_if: ALU request stream (valid/ready plus decoded payload).
// The master modport is the issue stage; the slave modport is the ALU.
interface alu_issue_stage_if #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
);

    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_WIDTH-1:0]     operand1;
    logic [DATA_WIDTH-1:0]     operand2;
    logic [6:0]                opcode;
    logic [2:0]                funct3;
    logic [6:0]                funct7;
    logic [REG_ADDR_WIDTH-1:0] rd;
    logic                      illegal;

    modport master (
        output out_valid, operand1, operand2, opcode, funct3, funct7, rd, illegal,
        input  out_ready
    );

    modport slave (
        input  out_valid, operand1, operand2, opcode, funct3, funct7, rd, illegal,
        output out_ready
    );

endinterface

// File: rtl/alu_skid_buffer.sv
// alu_skid_buffer: generic 2-entry valid/ready buffer.
// in_ready comes straight from the state register (not from out_ready), so
// the upstream path is cut. The output payload always comes from the main slot.
module alu_skid_buffer
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    E_BUF_STATE       state_q, state_d;
    logic [WIDTH-1:0] main_q, skid_q;
    logic             accept, drain;
    logic             load_main, load_skid, main_from_skid;

    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign accept    = in_valid && in_ready;
    assign drain     = out_valid && out_ready;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and slot load controls; flush overrides every transition
    always_comb begin
        state_d        = state_q;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d   = ONE;
                    load_main = 1'b1;
                end
            end
            ONE: begin
                if (accept && drain) begin
                    load_main = 1'b1;
                end else if (accept) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (drain) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (drain) begin
                    state_d        = ONE;
                    main_from_skid = 1'b1;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d        = EMPTY;
            load_main      = 1'b0;
            load_skid      = 1'b0;
            main_from_skid = 1'b0;
        end
    end

    // Payload slots; main holds while stalled, so the output stays stable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main) begin
                main_q <= in_data;
            end else if (main_from_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

endmodule

// File: rtl/alu_issue_stage.sv
// alu_issue_stage: decodes raw RV32I OP / OP-IMM words into ALU requests.
// It registers them through a 2-entry skid buffer and counts issued requests.
// Optional macro ALU_ISSUE_BYPASS_EN adds a writeback bypass onto the
// operand read path.
// The payload struct is sized by alu_pkg::XLEN/REG_AW, so DATA_WIDTH and
// REG_ADDR_WIDTH must match those values.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned INSTR_WIDTH    = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned CNT_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [INSTR_WIDTH-1:0]    in_instr,
    output logic [REG_ADDR_WIDTH-1:0] rs1_addr,
    output logic [REG_ADDR_WIDTH-1:0] rs2_addr,
    input  logic [DATA_WIDTH-1:0]     rs1_data,
    input  logic [DATA_WIDTH-1:0]     rs2_data,
`ifdef ALU_ISSUE_BYPASS_EN
    input  logic                      wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0]     wb_data,
`endif
    alu_issue_stage_if.master         alu_req,
    output logic [CNT_WIDTH-1:0]      issue_count
);

    alu_req_t              req_in, req_out;
    logic [DATA_WIDTH-1:0] src1, src2, imm_sext;
    logic [6:0]            opc;
    logic                  buf_out_valid;
    logic                  drain;

    assign rs1_addr = in_instr[RS1_MSB:RS1_LSB];
    assign rs2_addr = in_instr[RS2_MSB:RS2_LSB];
    assign opc      = in_instr[OPCODE_MSB:OPCODE_LSB];
    assign imm_sext = {{(DATA_WIDTH-IMM_W){in_instr[IMM_MSB]}}, in_instr[IMM_MSB:IMM_LSB]};

    // Operand sources: the writeback bypass beats the regfile, x0 beats both
    always_comb begin
        src1 = rs1_data;
        src2 = rs2_data;
`ifdef ALU_ISSUE_BYPASS_EN
        if (wb_valid && (wb_rd != '0) && (wb_rd == rs1_addr)) begin
            src1 = wb_data;
        end
        if (wb_valid && (wb_rd != '0) && (wb_rd == rs2_addr)) begin
            src2 = wb_data;
        end
`endif
        if (rs1_addr == '0) begin
            src1 = '0;
        end
        if (rs2_addr == '0) begin
            src2 = '0;
        end
    end

    // Decode: fields always pass through; operands are zero for non-ALU opcodes
    always_comb begin
        req_in         = '0;
        req_in.opcode  = opc;
        req_in.funct3  = in_instr[FUNCT3_MSB:FUNCT3_LSB];
        req_in.funct7  = in_instr[FUNCT7_MSB:FUNCT7_LSB];
        req_in.rd      = in_instr[RD_MSB:RD_LSB];
        req_in.illegal = !is_alu_opcode(opc);
        if (opc == OPCODE_OP) begin
            req_in.operand1 = src1;
            req_in.operand2 = src2;
        end else if (opc == OPCODE_OP_IMM) begin
            // Shift-immediates also use this path; the ALU reads shamt/SRA select from operand2
            req_in.operand1 = src1;
            req_in.operand2 = imm_sext;
        end
    end

    alu_skid_buffer #(
        .WIDTH($bits(alu_req_t))
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (req_in),
        .out_valid (buf_out_valid),
        .out_ready (alu_req.out_ready),
        .out_data  (req_out)
    );

    assign alu_req.out_valid = buf_out_valid;
    assign alu_req.operand1  = req_out.operand1;
    assign alu_req.operand2  = req_out.operand2;
    assign alu_req.opcode    = req_out.opcode;
    assign alu_req.funct3    = req_out.funct3;
    assign alu_req.funct7    = req_out.funct7;
    assign alu_req.rd        = req_out.rd;
    assign alu_req.illegal   = req_out.illegal;

    assign drain = buf_out_valid && alu_req.out_ready;

    // Issued-request counter; counts drains even in a flush cycle, wraps naturally
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            issue_count <= '0;
        end else if (drain) begin
            issue_count <= issue_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb_alu_issue_stage: directed and random stimulus for alu_issue_stage.
// The reference is an ordered queue of at most two expected requests plus a
// drain counter. The DUT counter is narrowed to 4 bits so that wrap is reachable.
module tb_alu_issue_stage;

    localparam int unsigned CNTW = 4;
`ifdef ALU_ISSUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [CNTW-1:0] issue_count;

    alu_issue_stage_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) req_if ();

    alu_issue_stage #(
        .DATA_WIDTH     (32),
        .INSTR_WIDTH    (32),
        .REG_ADDR_WIDTH (5),
        .CNT_WIDTH      (CNTW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .rs1_addr    (rs1_addr),
        .rs2_addr    (rs2_addr),
        .rs1_data    (rs1_data),
        .rs2_data    (rs2_data),
`ifdef ALU_ISSUE_BYPASS_EN
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
`endif
        .alu_req     (req_if),
        .issue_count (issue_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t        model_q[$];
    int unsigned model_cnt = 0;
    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    // Expected request computed from the ISA rules with plain arithmetic
    function automatic exp_t expect_req(input logic [31:0] ins, input logic [31:0] d1, input logic [31:0] d2);
        exp_t        r;
        int unsigned opc, r1, r2;
        logic [31:0] a, b;
        opc = ins % 128;
        r1  = (ins / 32768) % 32;
        r2  = (ins / 1048576) % 32;
        a = d1;
        b = d2;
        if (BYP && wb_valid && wb_rd != 0 && int'(wb_rd) == r1) a = wb_data;
        if (BYP && wb_valid && wb_rd != 0 && int'(wb_rd) == r2) b = wb_data;
        if (r1 == 0) a = 0;
        if (r2 == 0) b = 0;
        r.opc = 7'(opc);
        r.f3  = 3'((ins / 4096) % 8);
        r.f7  = 7'(ins / 33554432);
        r.rd  = 5'((ins / 128) % 32);
        if (opc == 'h33) begin
            r.op1 = a; r.op2 = b; r.ill = 1'b0;
        end else if (opc == 'h13) begin
            r.op1 = a; r.op2 = 32'($signed(ins) >>> 20); r.ill = 1'b0;
        end else begin
            r.op1 = 0; r.op2 = 0; r.ill = 1'b1;
        end
        return r;
    endfunction

    // One clock cycle: drive at the falling edge, check, then update the model at the rising edge
    task automatic step(input bit v, input logic [31:0] ins, input logic [31:0] d1, input logic [31:0] d2,
                        input bit ordy, input bit fl);
        exp_t e, e_new;
        bit   ex_ready, ex_valid, acc, drn;
        in_valid = v;
        in_instr = ins;
        rs1_data = d1;
        rs2_data = d2;
        req_if.out_ready = ordy;
        flush = fl;
        #1;
        ex_ready = (model_q.size() < 2);
        ex_valid = (model_q.size() != 0);
        chk("in_ready", 32'(in_ready), 32'(ex_ready));
        chk("out_valid", 32'(req_if.out_valid), 32'(ex_valid));
        chk("issue_count", 32'(issue_count), model_cnt % (1 << CNTW));
        chk("rs1_addr", 32'(rs1_addr), (ins / 32768) % 32);
        chk("rs2_addr", 32'(rs2_addr), (ins / 1048576) % 32);
        if (ex_valid) begin
            e = model_q[0];
            chk("operand1", req_if.operand1, e.op1);
            chk("operand2", req_if.operand2, e.op2);
            chk("opcode", 32'(req_if.opcode), 32'(e.opc));
            chk("funct3", 32'(req_if.funct3), 32'(e.f3));
            chk("funct7", 32'(req_if.funct7), 32'(e.f7));
            chk("rd", 32'(req_if.rd), 32'(e.rd));
            chk("illegal", 32'(req_if.illegal), 32'(e.ill));
        end
        acc = v && ex_ready;
        drn = ex_valid && ordy;
        e_new = expect_req(ins, d1, d2);
        @(posedge clk);
        if (drn) begin
            void'(model_q.pop_front());
            model_cnt++;
        end
        if (fl) model_q.delete();
        else if (acc) model_q.push_back(e_new);
        @(negedge clk);
    endtask

    localparam logic [31:0] I_ADD  = 32'h002081B3; // add  x3,x1,x2
    localparam logic [31:0] I_ADDI = 32'hFFF00093; // addi x1,x0,-1
    localparam logic [31:0] I_LW   = 32'h0040A283; // lw   x5,4(x1)
    localparam logic [31:0] I_SUB  = 32'h40520233; // sub  x4,x4,x5
    localparam logic [31:0] I_SRAI = 32'h4030D313; // srai x6,x1,3

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ins;
        int unsigned sel;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0;
        rs1_data = '0; rs2_data = '0; req_if.out_ready = 1'b0;
        wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
        #12;
        chk("rst_out_valid", 32'(req_if.out_valid), 0);
        chk("rst_in_ready", 32'(in_ready), 1);
        chk("rst_count", 32'(issue_count), 0);
        chk("rst_operand1", req_if.operand1, 0);
        chk("rst_operand2", req_if.operand2, 0);
        chk("rst_opcode", 32'(req_if.opcode), 0);
        chk("rst_illegal", 32'(req_if.illegal), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ADD with register operands
        step(1, I_ADD, 5, 7, 1, 0);
        chk("add_valid", 32'(req_if.out_valid), 1);
        chk("add_op1", req_if.operand1, 5);
        chk("add_op2", req_if.operand2, 7);
        chk("add_opcode", 32'(req_if.opcode), 'h33);
        chk("add_rd", 32'(req_if.rd), 3);
        chk("add_illegal", 32'(req_if.illegal), 0);

        // ADDI sign extension with x0 source
        step(1, I_ADDI, 32'h1234, 32'h99, 1, 0);
        chk("addi_op1", req_if.operand1, 0);
        chk("addi_op2", req_if.operand2, 32'hFFFF_FFFF);

        // Non-ALU opcode still issues, flagged illegal with zero operands
        step(1, I_LW, 32'h55, 32'h66, 1, 0);
        chk("lw_illegal", 32'(req_if.illegal), 1);
        chk("lw_op1", req_if.operand1, 0);
        chk("lw_op2", req_if.operand2, 0);
        step(0, 0, 0, 0, 1, 0);

        // Backpressure: three back-to-back words with the consumer stalled
        step(1, I_ADD, 32'h11, 32'h22, 0, 0);
        step(1, I_SUB, 32'h33, 32'h44, 0, 0);
        chk("bp_ready_low", 32'(in_ready), 0);
        step(1, I_SRAI, 32'h80000000, 32'h0, 0, 0);
        step(1, I_SRAI, 32'h80000000, 32'h0, 1, 0);
        step(1, I_SRAI, 32'h80000000, 32'h0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);

        // Flush in FULL with a word presented
        step(1, I_ADD, 1, 2, 0, 0);
        step(1, I_SUB, 3, 4, 0, 0);
        step(1, I_SRAI, 5, 6, 0, 1);
        chk("flush_valid", 32'(req_if.out_valid), 0);
        chk("flush_ready", 32'(in_ready), 1);
        // Flush in ONE together with accept and drain
        step(1, I_ADD, 7, 8, 0, 0);
        step(1, I_SUB, 9, 10, 1, 1);
        chk("flush2_valid", 32'(req_if.out_valid), 0);
        step(0, 0, 0, 0, 1, 0);

        // Asynchronous reset in the middle of a stream
        step(1, I_ADD, 1, 2, 0, 0);
        step(1, I_SUB, 3, 4, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", 32'(req_if.out_valid), 0);
        chk("mrst_ready", 32'(in_ready), 1);
        chk("mrst_count", 32'(issue_count), 0);
        chk("mrst_operand1", req_if.operand1, 0);
        chk("mrst_rd", 32'(req_if.rd), 0);
        model_q.delete();
        model_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;

        // Four drains, then wrap of the 4-bit counter
        for (int i = 0; i < 4; i++) step(1, I_ADD, i, i + 1, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("count4", 32'(issue_count), 4);
        for (int i = 0; i < 12; i++) step(1, I_SRAI, i, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        chk("count_wrap", 32'(issue_count), 0);

`ifdef ALU_ISSUE_BYPASS_EN
        wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'd9;
        step(1, I_ADD, 5, 7, 1, 0);
        chk("byp_op2", req_if.operand2, 9);
        wb_rd = 5'd0;
        step(1, I_ADD, 5, 7, 1, 0);
        chk("byp_x0_op2", req_if.operand2, 7);
        wb_valid = 1'b0;
        step(0, 0, 0, 0, 1, 0);
`endif

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            ins = $urandom;
            sel = $urandom_range(0, 4);
            if (sel <= 1) ins[6:0] = 7'h33;
            else if (sel <= 3) ins[6:0] = 7'h13;
            if ($urandom_range(0, 5) == 0) ins[19:15] = 5'd0;
            if ($urandom_range(0, 5) == 0) ins[24:20] = 5'd0;
            wb_valid = 1'($urandom_range(0, 1));
            wb_rd    = ($urandom_range(0, 1) == 1) ? ins[19:15] : 5'($urandom);
            wb_data  = $urandom;
            step(($urandom_range(0, 3) != 0), ins, $urandom, $urandom,
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
        end
        wb_valid = 1'b0;
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Producer side of the ALU operand/decode interface.
- Accepts raw RV32I instruction words over valid/ready and drives the regfile read addresses.
- Builds operand1/operand2 (register or sign-extended immediate) and passes opcode/funct3/funct7/rd through a 2-entry skid buffer.
- Sits between fetch and the single-cycle ALU; presents a registered, back-pressurable stream of ALU requests.

Parameters:
- DATA_WIDTH, 32, operand and register width.
- INSTR_WIDTH, 32, instruction word width.
- REG_ADDR_WIDTH, 5, register index width.
- CNT_WIDTH, 32, width of the issued-instruction counter.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- flush  in  1  synchronous; drops all buffered entries.
- in_valid  in  1  instruction word present.
- in_ready  out  1  stage can accept this cycle.
- in_instr  in  INSTR_WIDTH  raw instruction.
- rs1_addr  out  REG_ADDR_WIDTH  regfile read port 1 address, in_instr[19:15], combinational.
- rs2_addr  out  REG_ADDR_WIDTH  regfile read port 2 address, in_instr[24:20], combinational.
- rs1_data  in  DATA_WIDTH  same-cycle read data for rs1.
- rs2_data  in  DATA_WIDTH  same-cycle read data for rs2.
- out_valid  out  1  ALU request valid.
- out_ready  in  1  ALU consumer accepts.
- operand1  out  DATA_WIDTH  first ALU operand.
- operand2  out  DATA_WIDTH  second ALU operand.
- opcode  out  7  in_instr[6:0].
- funct3  out  3  in_instr[14:12].
- funct7  out  7  in_instr[31:25].
- rd  out  REG_ADDR_WIDTH  in_instr[11:7].
- illegal  out  1  opcode is neither 0110011 nor 0010011.
- issue_count  out  CNT_WIDTH  count of accepted output transfers.

Behaviour:
- Reset (rst_n=0, asynchronous): both slots empty, out_valid=0, in_ready=1, issue_count=0. All payload outputs read 0.
- Accept: an input transfer occurs when in_valid && in_ready.
- Opcode 0110011 (OP): operand1=rs1_data, operand2=rs2_data.
- Opcode 0010011 (OP-IMM): operand1=rs1_data, operand2=sign-extend(in_instr[31:20]). This also applies to shift-immediates, because the ALU reads operand2[4:0] for the amount and operand2[11:5] for the SRA select.
- Other opcodes: illegal=1, operand1=operand2=0, fields passed through. The entry is still issued; it is not dropped.
- Register x0: if the rs address is 0, the operand is 0 regardless of rsN_data.
- Latency: 1 cycle. An instruction accepted in cycle N appears on out_* in cycle N+1 when the output slot is empty.
- Buffer states:
  - EMPTY: out_valid=0.
  - ONE: main slot valid.
  - FULL: main and skid valid.
- in_ready is registered: in_ready = !FULL.
- Transitions:
  - EMPTY + accept -> ONE.
  - ONE + accept, no drain -> FULL; the new entry goes to skid.
  - ONE + accept + drain -> ONE; main is loaded with the new entry.
  - ONE + drain only -> EMPTY.
  - FULL + drain -> ONE; skid moves to main. in_ready=0 in FULL, so no accept is possible.
- Drain means out_valid && out_ready.
- Stability: out_* payload is stable while out_valid && !out_ready.
- flush: the next state is EMPTY regardless of any accept or drain that cycle. An instruction presented with flush=1 is discarded. issue_count still increments if a drain occurred that cycle.
- issue_count: increments by 1 per drain and wraps from 2^CNT_WIDTH-1 to 0.
- Reset mid-stream: all entries are lost immediately and the outputs return to reset values.

Optional Feature:
- Macro ALU_ISSUE_BYPASS_EN.
- When defined: adds ports wb_valid (in, 1), wb_rd (in, REG_ADDR_WIDTH) and wb_data (in, DATA_WIDTH).
- At accept, if wb_valid && wb_rd!=0 && wb_rd==rsN_addr, the operand takes wb_data instead of rsN_data. rs1 and rs2 are checked independently.
- x0 forcing still wins over the bypass.
- When undefined: the ports are absent and the operands come from rsN_data only.

Decomposition:
- Package alu_pkg:
  - OPCODE_OP=7'b0110011 and OPCODE_OP_IMM=7'b0010011.
  - Field bit-position localparams.
  - Packed struct alu_req_t {operand1, operand2, opcode, funct3, funct7, rd, illegal}.
  - E_BUF_STATE enum {EMPTY, ONE, FULL}.
- Sub-module alu_skid_buffer: a generic 2-entry valid/ready buffer parameterised on payload width, carrying alu_req_t.

Test Plan:
- ADD: in_instr=0x002081B3 (add x3,x1,x2), rs1_data=5, rs2_data=7, out_ready=1 -> next cycle out_valid=1, operand1=5, operand2=7, opcode=0x33, rd=3, illegal=0.
- Immediate sign-extension: addi x1,x0,-1 (0xFFF00093), rs1_data=0x1234 -> operand1=0 (x0), operand2=0xFFFFFFFF.
- Backpressure: out_ready=0 with 3 back-to-back valids -> in_ready=0 after the 2nd accept. Payload is held; releasing out_ready delivers instrs 1, 2, 3 in order with no loss or duplication.
- Illegal and counter: opcode 0x03 -> illegal=1, operands 0. After 4 drains, issue_count=4. Preload issue_count to 0xFFFFFFFF via 1-drain wrap check -> 0.
- Flush in FULL with in_valid=1 -> next cycle out_valid=0, in_ready=1, and the flushed entries never appear.
- Bypass (ALU_ISSUE_BYPASS_EN): add x3,x1,x2 with wb_valid=1, wb_rd=2, wb_data=9, rs2_data=7 -> operand2=9. With wb_rd=0 -> operand2=7.
